// File: rtl/uart8_transmitter_if.sv
// Handshake bundle for the 8N1 UART transmitter.
// en/start/in toward the transmitter; out/ready/busy/done back from it.
interface uart8_transmitter_if;
  logic       en;
  logic       start;
  logic [7:0] in;
  logic       out;
  logic       ready;
  logic       busy;
  logic       done;

  modport master (
    output en, start, in,
    input  out, ready, busy, done
  );

  modport slave (
    input  en, start, in,
    output out, ready, busy, done
  );
endinterface

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter, 8N1 (or 8N2), one-entry holding register.
// Ports: clk, reset (async, high); bus.slave = en/start/in -> out/ready/busy/done.
module uart8_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input logic                clk,
  input logic                reset,
  uart8_transmitter_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE * STOP_BITS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(OVERSAMPLE * STOP_BITS - 1);

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
      $error("OVERSAMPLE must be a power of 2 in 4..64");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_tick, w_tick;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_shift, w_shift;
  logic [7:0]    r_hold, w_hold;
  logic          r_full, w_full;
  logic          r_out, w_out;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          w_accept;

  assign w_accept = bus.start && !r_full && bus.en;

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_hold  = r_hold;
    w_full  = r_full;
    w_out   = r_out;
    w_busy  = r_busy;
    w_done  = 1'b0;
    if (!bus.en) begin
      // Disabled: abort any frame and park the line idle.
      w_state = IDLE;
      w_tick  = '0;
      w_idx   = '0;
      w_full  = 1'b0;
      w_out   = 1'b1;
      w_busy  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_full) begin
            w_shift = r_hold;
            w_full  = 1'b0;
            w_out   = 1'b0;
            w_tick  = '0;
            w_state = START_BIT;
          end
        end
        START_BIT: begin
          if (r_tick == BIT_LAST) begin
            w_out   = r_shift[0];
            w_idx   = 3'd1;
            w_tick  = '0;
            w_state = DATA_BITS;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        DATA_BITS: begin
          if (r_tick == BIT_LAST) begin
            w_tick = '0;
            // idx wrapped to 0 once data[7] was driven
            if (r_idx == 3'd0) begin
              w_out   = 1'b1;
              w_state = STOP_BIT;
            end else begin
              w_out = r_shift[r_idx];
              w_idx = r_idx + 3'd1;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        STOP_BIT: begin
          if (r_tick == STOP_LAST) begin
            w_done = 1'b1;
            w_tick = '0;
            if (r_full) begin
              w_shift = r_hold;
              w_full  = 1'b0;
              w_out   = 1'b0;
              w_state = START_BIT;
            end else begin
              w_busy  = 1'b0;
              w_state = IDLE;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
      // Only possible while holding is empty, so never races a load.
      if (w_accept) begin
        w_hold = bus.in;
        w_full = 1'b1;
        w_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_out   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_hold  <= w_hold;
      r_full  <= w_full;
      r_out   <= w_out;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.out   = r_out;
  assign bus.ready = !r_full && bus.en;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Directed bench for uart8_transmitter, 1 and 2 stop bits.
// Expected line/done/busy per clk derived from the frame timing.
module tb_uart8_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_r;
  logic       st;
  logic [7:0] din;
  bit         sel;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart8_transmitter_if ifa ();
  uart8_transmitter_if ifb ();

  assign ifa.en    = en_r;
  assign ifb.en    = en_r;
  assign ifa.in    = din;
  assign ifb.in    = din;
  assign ifa.start = st && !sel;
  assign ifb.start = st && sel;

  logic w_out, w_rdy, w_busy, w_done;
  assign w_out  = sel ? ifb.out   : ifa.out;
  assign w_rdy  = sel ? ifb.ready : ifa.ready;
  assign w_busy = sel ? ifb.busy  : ifa.busy;
  assign w_done = sel ? ifb.done  : ifa.done;

  uart8_transmitter #(
    .OVERSAMPLE(16),
    .STOP_BITS (1)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa.slave)
  );

  uart8_transmitter #(
    .OVERSAMPLE(16),
    .STOP_BITS (2)
  ) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Line level k clks after the accepting edge (single frame).
  function automatic logic f_line(
    input logic [7:0] b,
    input int         k
  );
    logic [7:0] v;
    v = b;
    if (k <= 16) return 1'b0;
    if (k <= 144) return v[(k - 17) / 16];
    return 1'b1;
  endfunction

  // Accept b0 at edge E, then check out/done/busy every clk.
  // two: queue b1 at E+3 and try an ignored 3C at E+11.
  // stop_at > 0: return after the check at that k.
  task automatic run(
    input bit         s,
    input logic [7:0] b0,
    input bit         two,
    input logic [7:0] b1,
    input int         stopc,
    input int         stop_at
  );
    int   len;
    int   last;
    logic eo;
    logic ed;
    logic eb;
    sel  = s;
    len  = 144 + stopc;
    last = two ? 2 * len + 3 : len + 3;
    @(negedge clk);
    chk("rdy_pre", w_rdy, 1);
    din = b0;
    st  = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk("acc_rdy", w_rdy, 0);
    chk("acc_busy", w_busy, 1);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (two && k > len) eo = f_line(b1, k - len);
      else eo = f_line(b0, k);
      ed = (k == len + 1) || (two && k == 2 * len + 1);
      eb = two ? (k <= 2 * len) : (k <= len);
      chk($sformatf("out_%0h_k%0d", b0, k), w_out, eo);
      chk($sformatf("done_%0h_k%0d", b0, k), w_done, ed);
      chk($sformatf("busy_%0h_k%0d", b0, k), w_busy, eb);
      if (k == 1) chk("rdy_k1", w_rdy, 1);
      if (two && k == 2) begin
        din = b1;
        st  = 1'b1;
      end else if (two && k == 3) begin
        st = 1'b0;
        chk("q_rdy", w_rdy, 0);
      end else if (two && k == 10) begin
        chk("ign_rdy", w_rdy, 0);
        din = 8'h3C;
        st  = 1'b1;
      end else if (two && k == 11) begin
        st = 1'b0;
      end
      if (k == stop_at) return;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit to);
    int n = 0;
    to = 1'b0;
    while (w_rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      to = 1'b1;
      return;
    end
    din = b;
    st  = 1'b1;
    @(negedge clk);
    st = 1'b0;
  endtask

  // Independent receiver: sample mid-bit after the falling edge.
  task automatic rx_byte(output logic [7:0] b, output bit err);
    int n = 0;
    b   = '0;
    err = 1'b0;
    while (w_out !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      err = 1'b1;
      return;
    end
    repeat (7) @(negedge clk);
    if (w_out !== 1'b0) err = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = w_out;
    end
    repeat (16) @(negedge clk);
    if (w_out !== 1'b1) err = 1'b1;
  endtask

  initial begin
    logic [7:0] lb [3];
    logic [7:0] got;
    bit         err;
    bit         to;
    reset = 1'b1;
    en_r  = 1'b1;
    st    = 1'b0;
    din   = '0;
    sel   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", w_out, 1);
    chk("rst_rdy", w_rdy, 1);
    chk("rst_busy", w_busy, 0);
    chk("rst_done", w_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out", w_out, 1);

    run(1'b0, 8'hA5, 1'b0, 8'h00, 16, 0);

    run(1'b0, 8'h00, 1'b1, 8'hFF, 16, 0);

    run(1'b0, 8'h55, 1'b0, 8'h00, 16, 70);
    en_r = 1'b0;
    #1;
    chk("ab_rdy0", w_rdy, 0);
    @(negedge clk);
    chk("ab_out", w_out, 1);
    chk("ab_busy", w_busy, 0);
    chk("ab_rdy", w_rdy, 0);
    chk("ab_done", w_done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_hold", w_out, 1);
    end
    en_r = 1'b1;
    #1;
    chk("ab_rdy1", w_rdy, 1);
    run(1'b0, 8'h81, 1'b0, 8'h00, 16, 0);

    run(1'b0, 8'hC3, 1'b0, 8'h00, 16, 150);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_out", w_out, 1);
    chk("ar_busy", w_busy, 0);
    chk("ar_done", w_done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("ar_nodone_%0d", k), w_done, 0);
      chk($sformatf("ar_idle_%0d", k), w_out, 1);
    end

    run(1'b1, 8'h96, 1'b0, 8'h00, 32, 0);

    sel   = 1'b0;
    lb[0] = 8'h00;
    lb[1] = 8'h5A;
    lb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      fork
        send_byte(lb[i], to);
        rx_byte(got, err);
      join
      chk($sformatf("lb_to_%0d", i), to, 0);
      chk($sformatf("lb_err_%0d", i), err, 0);
      chk($sformatf("lb_byte_%0d", i), got, lb[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
